microwave_countdown: RTL and testbench

Consumer end of the tick interface driven by the `Counter_100` divider chain: a BCD minutes:seconds countdown timer for the microwave controller. Keypad digits load the time. Start/stop/door events control the run. Each qualified `tick_i` pulse decrements the displayed time, and a one-cycle `done` pulse fires at 00:00. It sits between the divider chain, the keypad decoder and the display/magnetron control.

---
 rtl/microwave_countdown_pkg.sv | 21 ++
 rtl/microwave_countdown_bcd_dec4.sv | 43 ++++
 rtl/microwave_countdown.sv | 172 +++++++++++++++++
 tb/tb_microwave_countdown.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/microwave_countdown_pkg.sv
// Shared types and constants for the microwave countdown timer.
// The PAUSE encoding is always present; it is only reachable with MICROWAVE_PAUSE_EN.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_WRAP = 4'd5;
    localparam bcd_t BCD_WRAP      = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_WRAP;
    endfunction

endpackage

// File: rtl/microwave_countdown_bcd_dec4.sv
// Combinational mm:ss BCD decrement with per-position wrap limits.
// o_zero flags the input time as 00:00; o_last flags a result of 00:00.
module bcd_dec4
    import microwave_pkg::*;
(
    input  bcd_t i_min_tens,
    input  bcd_t i_min_ones,
    input  bcd_t i_sec_tens,
    input  bcd_t i_sec_ones,
    output bcd_t o_min_tens,
    output bcd_t o_min_ones,
    output bcd_t o_sec_tens,
    output bcd_t o_sec_ones,
    output logic o_zero,
    output logic o_last
);

    logic w_b0;
    logic w_b1;
    logic w_b2;

    // Borrows ripple through all four positions in a single cycle.
    always_comb begin
        w_b0 = (i_sec_ones == '0);
        w_b1 = w_b0 && (i_sec_tens == '0);
        w_b2 = w_b1 && (i_min_ones == '0);

        o_sec_ones = w_b0 ? BCD_WRAP : i_sec_ones - 4'd1;
        o_sec_tens = i_sec_tens;
        if (w_b0) begin
            o_sec_tens = (i_sec_tens == '0) ? SEC_TENS_WRAP : i_sec_tens - 4'd1;
        end
        o_min_ones = i_min_ones;
        if (w_b1) begin
            o_min_ones = (i_min_ones == '0) ? BCD_WRAP : i_min_ones - 4'd1;
        end
        o_min_tens = w_b2 ? i_min_tens - 4'd1 : i_min_tens;

        o_zero = ({i_min_tens, i_min_ones, i_sec_tens, i_sec_ones} == '0);
        o_last = ({o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} == '0);
    end

endmodule

// File: rtl/microwave_countdown.sv
// BCD mm:ss countdown timer driven by divider-chain ticks, keypad digits and door/stop events.
// Optional macro MICROWAVE_PAUSE_EN adds a PAUSE state that holds time and prescaler.
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

    state_t     r_state;
    logic [7:0] r_presc;
    bcd_t       r_mt, r_mo, r_st, r_so;
    logic       r_running, r_zero, r_done;

    state_t     w_state_nxt;
    logic [7:0] w_presc_nxt;
    bcd_t       w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic       w_running_nxt, w_zero_nxt, w_done_nxt;

    bcd_t       w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_is_zero, w_dec_last;
    logic       w_digit_ok;

    bcd_dec4 u_dec (
        .i_min_tens (r_mt),
        .i_min_ones (r_mo),
        .i_sec_tens (r_st),
        .i_sec_ones (r_so),
        .o_min_tens (w_dec_mt),
        .o_min_ones (w_dec_mo),
        .o_sec_tens (w_dec_st),
        .o_sec_ones (w_dec_so),
        .o_zero     (w_is_zero),
        .o_last     (w_dec_last)
    );

    assign w_digit_ok = digit_valid && is_bcd_digit(digit_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_mt      <= '0;
            r_mo      <= '0;
            r_st      <= '0;
            r_so      <= '0;
            r_running <= 1'b0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_mt      <= w_mt_nxt;
            r_mo      <= w_mo_nxt;
            r_st      <= w_st_nxt;
            r_so      <= w_so_nxt;
            r_running <= w_running_nxt;
            r_zero    <= w_zero_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_mt_nxt    = r_mt;
        w_mo_nxt    = r_mo;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (!w_is_zero && !door_open) begin
                            w_state_nxt = ST_RUN;
                            w_presc_nxt = '0;
                        end
                    end else if (!stop && w_digit_ok) begin
                        w_mt_nxt = r_mo;
                        w_mo_nxt = r_st;
                        w_st_nxt = r_so;
                        w_so_nxt = digit_in;
                    end
                end
                ST_RUN: begin
                    if (stop || door_open) begin
`ifdef MICROWAVE_PAUSE_EN
                        w_state_nxt = ST_PAUSE;
`else
                        w_state_nxt = ST_IDLE;
                        w_presc_nxt = '0;
                        if (stop) begin
                            {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = '0;
                        end
`endif
                    end else if (tick_i) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nxt = '0;
                            {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} =
                                {w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};
                            if (w_dec_last) begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_presc_nxt = r_presc + 8'd1;
                        end
                    end
                end
`ifdef MICROWAVE_PAUSE_EN
                ST_PAUSE: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                        w_presc_nxt = '0;
                        {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = '0;
                    end else if (start && !door_open) begin
                        w_state_nxt = ST_RUN;
                    end
                end
`endif
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = '0;
                end
            endcase
        end
    end

    // Flags are computed from next-state values so they line up with the registered digits.
    always_comb begin
        w_running_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt    = (w_state_nxt == ST_DONE);
        w_zero_nxt    = ({w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} == '0);
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = r_running;
    assign zero     = r_zero;
    assign done     = r_done;

endmodule

// File: tb/tb_microwave_countdown.sv
// Directed scoreboard bench for microwave_countdown at TICK_DIV=1 (dut_a) and TICK_DIV=100 (dut_b).
module tb_microwave_countdown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_a = 1'b0, tick_b = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, door_open = 1'b0;

    logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
    logic       a_run, a_zero, a_done, b_run, b_zero, b_done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        bit          b;
        logic [15:0] d;
        logic        run;
        logic        z;
        logic        dn;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    microwave_countdown #(.TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_a), .digit_in(digit_in), .digit_valid(digit_valid),
        .start(start), .stop(stop), .clear(clear), .door_open(door_open),
        .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
        .running(a_run), .zero(a_zero), .done(a_done)
    );

    microwave_countdown #(.TICK_DIV(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_b), .digit_in(digit_in), .digit_valid(digit_valid),
        .start(start), .stop(stop), .clear(clear), .door_open(door_open),
        .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
        .running(b_run), .zero(b_zero), .done(b_done)
    );

    function automatic logic [15:0] mmss(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input bit b, input logic [15:0] d,
                        input logic run, input logic z, input logic dn);
        exp_t e;
        e.tag = tag; e.b = b; e.d = d; e.run = run; e.z = z; e.dn = dn;
        q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        logic [15:0] od;
        logic orun, oz, odn;
        e = q.pop_front();
        if (e.b) begin
            od = {b_mt, b_mo, b_st, b_so}; orun = b_run; oz = b_zero; odn = b_done;
        end else begin
            od = {a_mt, a_mo, a_st, a_so}; orun = a_run; oz = a_zero; odn = a_done;
        end
        n_assert++;
        assert (od === e.d) else begin
            n_fail++; $error("FAIL %s digits observed=%h expected=%h", e.tag, od, e.d);
        end
        n_assert++;
        assert (orun === e.run) else begin
            n_fail++; $error("FAIL %s running observed=%b expected=%b", e.tag, orun, e.run);
        end
        n_assert++;
        assert (oz === e.z) else begin
            n_fail++; $error("FAIL %s zero observed=%b expected=%b", e.tag, oz, e.z);
        end
        n_assert++;
        assert (odn === e.dn) else begin
            n_fail++; $error("FAIL %s done observed=%b expected=%b", e.tag, odn, e.dn);
        end
    endtask

    // Drive one input cycle, then compare against what was queued for it.
    task automatic expect_a(input string tag, input logic [15:0] d, input logic run,
                            input logic z, input logic dn);
        push(tag, 1'b0, d, run, z, dn);
        clk1();
        chk();
    endtask

    task automatic key(input logic [3:0] d);
        digit_in = d;
        digit_valid = 1'b1;
    endtask

    task automatic idle_in();
        digit_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        tick_a = 1'b0; tick_b = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        clk1(); clk1();
        rst_n = 1'b1;
        push("reset", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); chk();

        // TICK_DIV=100 on dut_b, 00:02
        key(4'd0); clk1(); idle_in();
        key(4'd2); clk1(); idle_in();
        start = 1'b1;
        push("b_start", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        clk1(); idle_in(); chk();
        for (int k = 1; k <= 200; k++) begin
            tick_b = 1'b1;
            clk1();
            if (k == 99)  begin push("b_tick99",  1'b1, 16'h0002, 1'b1, 1'b0, 1'b0); chk(); end
            if (k == 100) begin push("b_tick100", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0); chk(); end
            if (k == 199) begin push("b_tick199", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0); chk(); end
            if (k == 200) begin push("b_tick200", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1); chk(); end
        end
        idle_in();
        push("b_after_done", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0); clk1(); chk();

        clear = 1'b1;
        push("a_clear", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); clk1(); idle_in(); chk();

        // Digit entry
        key(4'd12); expect_a("key_12_ignored", 16'h0000, 1'b0, 1'b1, 1'b0); idle_in();
        key(4'd1);  expect_a("key_1", 16'h0001, 1'b0, 1'b0, 1'b0); idle_in();
        key(4'd2);  clk1(); key(4'd3); clk1(); key(4'd4); clk1();
        key(4'd5);  expect_a("key_5digits", 16'h2345, 1'b0, 1'b0, 1'b0); idle_in();
        key(4'hA);  expect_a("key_A_ignored", 16'h2345, 1'b0, 1'b0, 1'b0); idle_in();
        start = 1'b1; expect_a("start_2345", 16'h2345, 1'b1, 1'b0, 1'b0); idle_in();
        key(4'd7);  expect_a("key_in_run", 16'h2345, 1'b1, 1'b0, 1'b0); idle_in();
        clear = 1'b1; expect_a("clear_in_run", 16'h0000, 1'b0, 1'b1, 1'b0); idle_in();

        // 01:30 full countdown
        key(4'd1); clk1(); key(4'd3); clk1(); key(4'd0); clk1(); idle_in();
        start = 1'b1; expect_a("start_0130", 16'h0130, 1'b1, 1'b0, 1'b0); idle_in();
        for (int k = 1; k <= 90; k++) begin
            tick_a = 1'b1;
            push("countdown", 1'b0, mmss(90 - k), (k != 90), (k == 90), (k == 90));
            clk1();
            chk();
        end
        expect_a("tick_in_done", 16'h0000, 1'b0, 1'b1, 1'b0);
        idle_in();
        expect_a("idle_after_done", 16'h0000, 1'b0, 1'b1, 1'b0);

        // 00:90 keeps its non-normalised tens digit
        key(4'd9); clk1(); key(4'd0); clk1(); idle_in();
        start = 1'b1; expect_a("start_0090", 16'h0090, 1'b1, 1'b0, 1'b0); idle_in();
        tick_a = 1'b1; expect_a("dec_0090", 16'h0089, 1'b1, 1'b0, 1'b0); idle_in();

        // Reset mid-run at 01:30
        clear = 1'b1; clk1(); idle_in();
        key(4'd1); clk1(); key(4'd3); clk1(); key(4'd0); clk1(); idle_in();
        start = 1'b1; expect_a("start_rst", 16'h0130, 1'b1, 1'b0, 1'b0); idle_in();
        rst_n = 1'b0; expect_a("reset_mid_run", 16'h0000, 1'b0, 1'b1, 1'b0); rst_n = 1'b1;

        // Stop coincident with a qualifying tick at 00:10
        key(4'd1); clk1(); key(4'd0); clk1(); idle_in();
        start = 1'b1; expect_a("start_0010", 16'h0010, 1'b1, 1'b0, 1'b0); idle_in();
        stop = 1'b1; tick_a = 1'b1;
`ifdef MICROWAVE_PAUSE_EN
        expect_a("stop_tick_pause", 16'h0010, 1'b0, 1'b0, 1'b0); idle_in();
        start = 1'b1; expect_a("resume", 16'h0010, 1'b1, 1'b0, 1'b0); idle_in();
        tick_a = 1'b1; expect_a("resume_tick", 16'h0009, 1'b1, 1'b0, 1'b0); idle_in();
`else
        expect_a("stop_tick_clear", 16'h0000, 1'b0, 1'b1, 1'b0); idle_in();
        start = 1'b1; expect_a("start_at_zero", 16'h0000, 1'b0, 1'b1, 1'b0); idle_in();
`endif
        clear = 1'b1; clk1(); idle_in();

        // Door interlock
        key(4'd5); clk1(); idle_in();
        door_open = 1'b1; start = 1'b1;
        expect_a("start_door_open", 16'h0005, 1'b0, 1'b0, 1'b0); idle_in();
        door_open = 1'b0;
        start = 1'b1; expect_a("start_door_closed", 16'h0005, 1'b1, 1'b0, 1'b0); idle_in();
        tick_a = 1'b1; expect_a("door_tick1", 16'h0004, 1'b1, 1'b0, 1'b0);
        expect_a("door_tick2", 16'h0003, 1'b1, 1'b0, 1'b0);
        door_open = 1'b1;
        expect_a("door_open_run", 16'h0003, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            expect_a("door_held", 16'h0003, 1'b0, 1'b0, 1'b0);
        end
        idle_in();
        door_open = 1'b0;
        start = 1'b1; expect_a("door_restart", 16'h0003, 1'b1, 1'b0, 1'b0); idle_in();
        tick_a = 1'b1; expect_a("door_restart_tick", 16'h0002, 1'b1, 1'b0, 1'b0); idle_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
